// File: rtl/fp_accum_pkg.sv
// Shared types and constants for the FP32 streaming sum-reduction sequencer.
package fp_accum_pkg;

    localparam int FP32_W = 32;

    localparam logic [FP32_W-1:0] FP32_POS_ZERO = 32'h0000_0000;
    localparam logic [FP32_W-1:0] FP32_QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        FIRST,
        NEXT,
        ISSUE,
        ACK,
        WAITZ,
        EMIT
    } fp_accum_state_t;

    // Operand pair handed to the adder driver.
    typedef struct packed {
        logic [FP32_W-1:0] a;
        logic [FP32_W-1:0] b;
    } add_req_t;

endpackage

// File: rtl/fp_accum_seq.sv
// Folds a valid/ready stream of FP32 elements into one sum via an external adder driver.
// Latency: single element -> result next cycle; otherwise per add 2 cycles + driver latency + 1.
// Backpressure: in_ready low while an add is in flight or a result is held; out_* held until out_ready.
module fp_accum_seq
    import fp_accum_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FP32_W-1:0] in_data,
    input  logic              in_last,
    output logic              add_start,
    output logic [FP32_W-1:0] add_a,
    output logic [FP32_W-1:0] add_b,
    input  logic              add_busy,
    input  logic              add_done,
    input  logic [FP32_W-1:0] add_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FP32_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    fp_accum_state_t   state, state_nxt;
    logic [FP32_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              sat;
    logic              last;
    add_req_t          req;
    logic              in_fire;
    logic              z_fire;

    assign in_fire = in_valid && in_ready;
    // add_busy gating keeps a stale done from the previous add from being taken as fresh.
    assign z_fire  = (state == WAITZ) && add_done && !add_busy;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        add_start = 1'b0;
        out_valid = 1'b0;
        case (state)
            FIRST: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = in_last ? EMIT : NEXT;
            end
            NEXT: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ISSUE;
            end
            ISSUE: begin
                add_start = !add_busy;
                if (!add_busy) state_nxt = ACK;
            end
            ACK: begin
                if (add_busy) state_nxt = WAITZ;
            end
            WAITZ: begin
                if (add_done && !add_busy) state_nxt = last ? EMIT : NEXT;
            end
            EMIT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = FIRST;
            end
            default: state_nxt = FIRST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= FP32_POS_ZERO;
            cnt  <= '0;
            sat  <= 1'b0;
            last <= 1'b0;
            req  <= '0;
        end else begin
            if (in_fire && state == FIRST) begin
                acc <= in_data;
                cnt <= CNT_W'(1);
                sat <= 1'b0;
            end
            if (in_fire && state == NEXT) begin
                req.a <= acc;
                req.b <= in_data;
                last  <= in_last;
                if (cnt == '1) begin
                    sat <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
            if (z_fire) begin
                acc <= add_z;
            end
        end
    end

    assign add_a     = req.a;
    assign add_b     = req.b;
    assign out_sum   = acc;
    assign out_count = cnt;
    assign out_sat   = sat;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Scoreboard bench for fp_accum_seq with a behavioural fp_adder_driver stand-in.
module tb_fp_accum_seq;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid, in_ready, in_last;
    logic [31:0]      in_data;
    logic             add_start, add_busy, add_done;
    logic [31:0]      add_a, add_b, add_z;
    logic             out_valid, out_ready, out_sat;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;

    int n_cmp = 0;
    int n_err = 0;

    fp_accum_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_busy  (add_busy),
        .add_done  (add_done),
        .add_z     (add_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Exact for the normal/zero operands used here.
    function automatic real f32_to_real(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:0] == 31'h0) d = {f[31], 63'h0};
        else d = {f[31], 11'(32'(f[30:23]) - 127 + 1023), f[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        return {d[63], 8'(32'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    // Driver model: optional accept delay (stale done stays high), then busy for cfg_lat+1 cycles.
    int   cfg_acc_dly = 0;
    int   cfg_lat = 2;
    int   pcnt, rcnt;
    logic pending;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_busy <= 1'b0;
            add_done <= 1'b0;
            add_z    <= 32'h0;
            pending  <= 1'b0;
            pcnt     <= 0;
            rcnt     <= 0;
        end else if (add_start) begin
            pending <= 1'b1;
            pcnt    <= cfg_acc_dly;
        end else if (pending) begin
            if (pcnt == 0) begin
                pending  <= 1'b0;
                add_busy <= 1'b1;
                add_done <= 1'b0;
                rcnt     <= cfg_lat;
            end else begin
                pcnt <= pcnt - 1;
            end
        end else if (add_busy) begin
            if (rcnt == 0) begin
                add_busy <= 1'b0;
                add_done <= 1'b1;
                add_z    <= real_to_f32(f32_to_real(add_a) + f32_to_real(add_b));
            end else begin
                rcnt <= rcnt - 1;
            end
        end
    end

    typedef struct {
        logic [31:0] sum;
        logic [7:0]  cnt;
        logic        sat;
        int          adds;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] vec_q[$];

    // Monitor: pops the scoreboard on every output handshake, checks hold stability.
    logic [31:0] p_sum;
    logic [7:0]  p_cnt;
    logic        p_sat;
    logic        p_hold = 1'b0;
    logic        p_start = 1'b0;
    int          n_adds = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            p_hold  = 1'b0;
            p_start = 1'b0;
            n_adds  = 0;
        end else begin
            if (add_start) begin
                n_adds++;
                chk("start_one_cycle", 32'(p_start), 32'(0));
            end
            p_start = add_start;
            if (p_hold) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_sum", out_sum, p_sum);
                chk("hold_count", 32'(out_count), 32'(p_cnt));
                chk("hold_sat", 32'(out_sat), 32'(p_sat));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got sum %h with empty scoreboard", out_sum);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_sum", out_sum, e.sum);
                    chk("out_count", 32'(out_count), 32'(e.cnt));
                    chk("out_sat", 32'(out_sat), 32'(e.sat));
                    chk("add_pulses", 32'(n_adds), 32'(e.adds));
                end
                n_adds = 0;
            end
            p_hold = out_valid && !out_ready;
            p_sum  = out_sum;
            p_cnt  = out_count;
            p_sat  = out_sat;
        end
    end

    task automatic push_exp(input logic [31:0] s, input logic [7:0] c, input logic st, input int a);
        exp_t e;
        e.sum = s; e.cnt = c; e.sat = st; e.adds = a;
        sb_q.push_back(e);
    endtask

    // Drives vec_q one element at a time; returns at posedge+1 right after the last accept.
    task automatic send_vec();
        logic hs;
        for (int i = 0; i < vec_q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = vec_q[i];
            in_last  = (i == vec_q.size() - 1);
            hs = 1'b0;
            for (int b = 0; b < 200 && !hs; b++) begin
                @(negedge clk);
                hs = in_ready;
                @(posedge clk);
                #1;
            end
            if (!hs) begin
                n_cmp++;
                n_err++;
                $display("FAIL in_accept_timeout: element %0d not accepted", i);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        logic ok;
        ok = 1'b0;
        for (int b = 0; b < 500 && !ok; b++) begin
            @(negedge clk);
            ok = (sb_q.size() == 0) && in_ready;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: pending=%0d in_ready=%b", name, sb_q.size(), in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(1));
        chk({tag, "_add_start"}, 32'(add_start), 32'(0));
        chk({tag, "_add_a"}, add_a, 32'h0);
        chk({tag, "_add_b"}, add_b, 32'h0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_out_sum"}, out_sum, 32'h0);
        chk({tag, "_out_count"}, 32'(out_count), 32'(0));
        chk({tag, "_out_sat"}, 32'(out_sat), 32'(0));
    endtask

    initial begin
        logic seen;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        #1;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1 + 2 + 3 = 6
        push_exp(32'h40C0_0000, 8'd3, 1'b0, 2);
        vec_q = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};
        send_vec();
        wait_idle("sum123");

        // single -0.0, no add, result the next cycle
        push_exp(32'h8000_0000, 8'd1, 1'b0, 0);
        vec_q = '{32'h8000_0000};
        send_vec();
        @(negedge clk);
        chk("single_next_cycle_valid", 32'(out_valid), 32'(1));
        wait_idle("single");

        // 0.5 + -0.5 held against backpressure
        out_ready = 1'b0;
        push_exp(32'h0000_0000, 8'd2, 1'b0, 1);
        vec_q = '{32'h3F00_0000, 32'hBF00_0000};
        send_vec();
        seen = 1'b0;
        for (int b = 0; b < 100 && !seen; b++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("hold_reached_emit", 32'(seen), 32'(1));
        for (int k = 0; k < 10; k++) begin
            chk("hold_in_ready_low", 32'(in_ready), 32'(0));
            chk("hold_sum_zero", out_sum, 32'h0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("in_ready_after_handshake", 32'(in_ready), 32'(1));
        wait_idle("hold");

        // stale done (z=0) stays high while the driver delays accepting: 10 + 5 = 15
        cfg_acc_dly = 3;
        push_exp(32'h4170_0000, 8'd2, 1'b0, 1);
        vec_q = '{32'h4120_0000, 32'h40A0_0000};
        send_vec();
        wait_idle("stale_done");
        cfg_acc_dly = 0;

        // 300 x 1.0 saturates the count at 255
        cfg_lat = 1;
        push_exp(32'h4396_0000, 8'd255, 1'b1, 299);
        vec_q.delete();
        for (int i = 0; i < 300; i++) vec_q.push_back(32'h3F80_0000);
        send_vec();
        wait_idle("sat300");

        // reset while waiting on the adder result
        cfg_lat = 4;
        vec_q = '{32'h3F80_0000, 32'h4000_0000};
        send_vec();
        seen = 1'b0;
        for (int b = 0; b < 100 && !seen; b++) begin
            @(negedge clk);
            seen = add_busy;
        end
        chk("reset_reached_waitz", 32'(seen), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cfg_lat = 2;
        push_exp(32'h4080_0000, 8'd2, 1'b0, 1);
        vec_q = '{32'h4000_0000, 32'h4000_0000};
        send_vec();
        wait_idle("after_reset");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
